neuron: RTL and testbench



---
 rtl/neuron_pkg.sv | 17 +
 rtl/neuron_if.sv | 10 +
 rtl/neuron_unit.sv | 55 +++++
 rtl/neuron.sv | 89 ++++++++
 tb/tb_neuron.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared widths, signed arithmetic types and the step activation for the neuron tile.
package neuron_pkg;

    localparam int IN_W   = 4;
    localparam int WT_W   = 4;
    localparam int BIAS_W = 8;
    localparam int ACC_W  = 10;

    typedef logic signed [WT_W-1:0]   wt_t;
    typedef logic signed [BIAS_W-1:0] bias_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    function automatic logic step_fire(input acc_t acc);
        return (acc >= acc_t'(0));
    endfunction

endpackage

// File: rtl/neuron_if.sv
// Tile I/O bundle: io_in carries clock, reset and data; io_out carries the result.
interface neuron_if;

    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);

endinterface

// File: rtl/neuron_unit.sv
// Two-input weighted-sum neuron with a registered step output.
// With NEURON_DEBUG_EN defined it also exposes its registered accumulator.
module neuron_unit
    import neuron_pkg::*;
#(
    parameter int    IN_WIDTH = IN_W,
    parameter wt_t   WA       = wt_t'(1),
    parameter wt_t   WB       = wt_t'(1),
    parameter bias_t B        = bias_t'(0)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [IN_WIDTH-1:0] i_a,
    input  logic [IN_WIDTH-1:0] i_b,
`ifdef NEURON_DEBUG_EN
    output acc_t                o_acc,
`endif
    output logic                o_fire
);

    acc_t w_a;
    acc_t w_b;
    acc_t w_acc;
    logic r_fire;

    // Inputs are unsigned; zero-extend before the signed multiply.
    assign w_a   = acc_t'({{(ACC_W-IN_WIDTH){1'b0}}, i_a});
    assign w_b   = acc_t'({{(ACC_W-IN_WIDTH){1'b0}}, i_b});
    assign w_acc = w_a * acc_t'(WA) + w_b * acc_t'(WB) + acc_t'(B);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fire <= 1'b0;
        end else begin
            r_fire <= step_fire(w_acc);
        end
    end

    assign o_fire = r_fire;

`ifdef NEURON_DEBUG_EN
    acc_t r_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc;
        end
    end

    assign o_acc = r_acc;
`endif

endmodule

// File: rtl/neuron.sv
// Fixed-weight 2-2-1 step network on an 8-bit tile bus; io_out[0] is the band detector.
// Define NEURON_DEBUG_EN to expose n1, n2 and n3's accumulator on io_out[7:1].
module neuron
    import neuron_pkg::*;
#(
    parameter wt_t   W10 = wt_t'(1),
    parameter wt_t   W11 = wt_t'(1),
    parameter bias_t B1  = bias_t'(-4),
    parameter wt_t   W20 = wt_t'(1),
    parameter wt_t   W21 = wt_t'(1),
    parameter bias_t B2  = bias_t'(-12),
    parameter wt_t   W31 = wt_t'(2),
    parameter wt_t   W32 = wt_t'(-2),
    parameter bias_t B3  = bias_t'(-1)
) (
    neuron_if.slave bus
);

    logic            w_clk;
    logic            w_rst_n;
    logic [IN_W-1:0] w_x0;
    logic [IN_W-1:0] w_x1;
    logic            w_n1;
    logic            w_n2;
    logic            w_n3;

    // x0 and x1 deliberately overlap on io_in[5:4].
    assign w_clk   = bus.io_in[0];
    assign w_rst_n = bus.io_in[1];
    assign w_x0    = bus.io_in[5:2];
    assign w_x1    = bus.io_in[7:4];

    neuron_unit #(.IN_WIDTH(IN_W), .WA(W10), .WB(W11), .B(B1)) u_n1 (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_a     (w_x0),
        .i_b     (w_x1),
`ifdef NEURON_DEBUG_EN
        .o_acc   (),
`endif
        .o_fire  (w_n1)
    );

    neuron_unit #(.IN_WIDTH(IN_W), .WA(W20), .WB(W21), .B(B2)) u_n2 (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_a     (w_x0),
        .i_b     (w_x1),
`ifdef NEURON_DEBUG_EN
        .o_acc   (),
`endif
        .o_fire  (w_n2)
    );

`ifdef NEURON_DEBUG_EN
    acc_t w_acc3;
    logic r_n1_d;
    logic r_n2_d;
`endif

    neuron_unit #(.IN_WIDTH(1), .WA(W31), .WB(W32), .B(B3)) u_n3 (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_a     (w_n1),
        .i_b     (w_n2),
`ifdef NEURON_DEBUG_EN
        .o_acc   (w_acc3),
`endif
        .o_fire  (w_n3)
    );

`ifdef NEURON_DEBUG_EN
    // n1/n2 are delayed one stage so the debug view matches the n3 they produced.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_n1_d <= 1'b0;
            r_n2_d <= 1'b0;
        end else begin
            r_n1_d <= w_n1;
            r_n2_d <= w_n2;
        end
    end

    assign bus.io_out = {w_acc3[ACC_W-1], w_acc3[3:0], r_n2_d, r_n1_d, w_n3};
`else
    assign bus.io_out = {7'b0, w_n3};
`endif

endmodule

// File: tb/tb_neuron.sv
// Scoreboard bench for the neuron tile: stimulus queues expected io_out, a monitor checks it.
module tb_neuron;

    logic       r_clk   = 1'b0;
    logic       r_rst_n = 1'b0;
    logic [5:0] r_data  = '1;
    int         cyc     = 0;

    typedef struct {
        int         due;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    neuron_if tb_if ();

    assign tb_if.io_in = {r_data, r_rst_n, r_clk};

    neuron dut (.bus(tb_if));

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) cyc <= cyc + 1;

    // n3 accumulator is 2*n1 - 2*n2 - 1 with default weights.
    function automatic logic [7:0] exp_out(input bit n1, input bit n2, input bit n3);
        logic signed [9:0] acc;
        logic [7:0]        full;
        acc  = 10'(2 * int'(n1) - 2 * int'(n2) - 1);
        full = {acc[9], acc[3:0], n2, n1, n3};
`ifdef NEURON_DEBUG_EN
        return full;
`else
        return full & 8'h01;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: io_out=%h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a falling edge; n3 for this input is visible after the second rising edge.
    task automatic apply(input string tag, input logic [5:0] d, input bit n1, input bit n2, input bit n3);
        exp_t e;
        r_data = d;
        e.due  = cyc + 2;
        e.exp  = exp_out(n1, n2, n3);
        e.tag  = tag;
        sbq.push_back(e);
        @(negedge r_clk);
    endtask

    task automatic release_rst();
        exp_t e;
        r_rst_n = 1'b1;
        e.due   = cyc + 1;
        e.exp   = exp_out(1'b0, 1'b0, 1'b0);
        e.tag   = "post_reset_edge1";
        sbq.push_back(e);
    endtask

    task automatic async_reset(input int hold);
        #2;
        r_rst_n = 1'b0;
        sbq.delete();
        #1;
        check("async_clear", tb_if.io_out, 8'h00);
        repeat (hold) @(negedge r_clk);
        release_rst();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge r_clk);
            #1;
            if (!r_rst_n) begin
                check("reset_hold", tb_if.io_out, 8'h00);
            end else begin
                while (sbq.size() > 0 && sbq[0].due < cyc) begin
                    e = sbq.pop_front();
                    n_vec++;
                    n_bad++;
                    $display("FAIL %s: not sampled, io_out=%h expected %h", e.tag, tb_if.io_out, e.exp);
                end
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    e = sbq.pop_front();
                    check(e.tag, tb_if.io_out, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int wait_cyc;
        repeat (3) @(negedge r_clk);
        release_rst();

        // x0=6, x1=1 (s=7) held
        apply("s7_hold_a",  6'b000110, 1, 0, 1);
        apply("s7_hold_b",  6'b000110, 1, 0, 1);
        // x0=12, x1=3 (s=15) held
        apply("s15_hold_a", 6'b001100, 1, 1, 0);
        apply("s15_hold_b", 6'b001100, 1, 1, 0);
        // zero, then s=4 (x0=0, x1=4; acc1=0 fires)
        apply("s0_a",       6'b000000, 0, 0, 0);
        apply("s0_b",       6'b000000, 0, 0, 0);
        apply("s4_edge_a",  6'b010000, 1, 0, 1);
        apply("s4_edge_b",  6'b010000, 1, 0, 1);
        // band edges
        apply("s11",        6'b001001, 1, 0, 1);
        apply("s12_a",      6'b001010, 1, 1, 0);
        apply("s12_b",      6'b110000, 1, 1, 0);
        apply("s3",         6'b000011, 0, 0, 0);
        apply("s30",        6'b111111, 1, 1, 0);
        // back-to-back stream
        apply("bb_s7",      6'b000110, 1, 0, 1);
        apply("bb_s15",     6'b001100, 1, 1, 0);
        apply("bb_s0",      6'b000000, 0, 0, 0);
        apply("bb_s5",      6'b000100, 1, 0, 1);
        apply("bb_s7b",     6'b000110, 1, 0, 1);
        // io_out[0] is high here; reset mid-stream discards in-flight results
        async_reset(2);
        apply("rs_s5",      6'b000100, 1, 0, 1);
        apply("rs_s15",     6'b001100, 1, 1, 0);
        apply("rs_s7",      6'b000110, 1, 0, 1);
        apply("rs_s0",      6'b000000, 0, 0, 0);

        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 10) begin
            @(negedge r_clk);
            wait_cyc++;
        end
        #2;
        if (sbq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected results never checked, required 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
